// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into SEG-bit
// segments, one segment resolved per stage, with a global valid/ready stall.
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    // Operands ride along so later segments can be computed; sum holds the
    // bits resolved so far, carry is the carry into the next segment.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
    } stage_t;

    stage_t            stage_r     [STAGES];
    stage_t            src_s       [STAGES];
    stage_t            nxt_s       [STAGES];
    logic [SEG:0]      seg_res_s   [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] src_valid_s;
    logic              en_s;
    logic              ovf_r;
    logic              zero_r;
    logic              last_ovf_s;
    logic              last_zero_s;

    assign en_s = !valid_r[LAST] || out_ready;

    // Select each stage's source: ports for stage 0, previous stage otherwise.
    always_comb begin
        src_s[0].a       = a;
        src_s[0].b       = sub ? ~b : b;
        src_s[0].sum     = {WIDTH{1'b0}};
        src_s[0].carry   = carry_in;
        src_valid_s[0]   = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            src_s[i]       = stage_r[i-1];
            src_valid_s[i] = valid_r[i-1];
        end
    end

    // Resolve segment i in stage i from the incoming carry.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            seg_res_s[i] = {1'b0, src_s[i].a[i*SEG +: SEG]}
                         + {1'b0, src_s[i].b[i*SEG +: SEG]}
                         + {{SEG{1'b0}}, src_s[i].carry};
            nxt_s[i]                    = src_s[i];
            nxt_s[i].sum[i*SEG +: SEG]  = seg_res_s[i][SEG-1:0];
            nxt_s[i].carry              = seg_res_s[i][SEG];
        end
    end

    // Flags for the final stage, registered alongside the completed sum.
    always_comb begin
        last_ovf_s  = (nxt_s[LAST].a[WIDTH-1] == nxt_s[LAST].b[WIDTH-1])
                   && (nxt_s[LAST].sum[WIDTH-1] != nxt_s[LAST].a[WIDTH-1]);
        last_zero_s = (nxt_s[LAST].sum == {WIDTH{1'b0}});
    end

    // Pipeline advance: all stages shift together; data only captured when valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {$bits(stage_t){1'b0}};
            end
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (en_s) begin
            valid_r <= src_valid_s;
            for (int i = 0; i < STAGES; i++) begin
                if (src_valid_s[i]) begin
                    stage_r[i] <= nxt_s[i];
                end
            end
            if (src_valid_s[LAST]) begin
                ovf_r  <= last_ovf_s;
                zero_r <= last_zero_s;
            end
        end
    end

    assign in_ready  = en_s;
    assign out_valid = valid_r[LAST];
    assign sum       = stage_r[LAST].sum;
    assign carry_out = stage_r[LAST].carry;
    assign overflow  = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed vector table, random stream
// against an arithmetic reference model, backpressure and mid-flight reset.
module tb_adder_pipe;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int LAT   = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        res_t        r;
    } vec_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_no  = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    int   ret_count, first_ret, last_ret;

    // Reference: plain wide arithmetic, overflow from the true signed result range.
    function automatic res_t model(input logic [31:0] fa, input logic [31:0] fb,
                                   input logic fsub, input logic fcin);
        res_t        r;
        logic [31:0] be;
        logic [63:0] u;
        longint      s;
        be = fsub ? ~fb : fb;
        u  = {32'd0, fa} + {32'd0, be} + {63'd0, fcin};
        s  = longint'($signed(fa)) + longint'($signed(be)) + longint'({63'd0, fcin});
        r.sum  = u[31:0];
        r.co   = u[32];
        r.ovf  = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        r.zero = (u[31:0] == 32'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One cycle: record handshakes of the current cycle, then advance to next negedge.
    task automatic tick();
        res_t e;
        #1;
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sub, carry_in));
            n_push++;
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got sum 0x%0h with no operation outstanding", sum);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum", 64'(sum), 64'(e.sum));
                chk("sb_carry_out", 64'(carry_out), 64'(e.co));
                chk("sb_overflow", 64'(overflow), 64'(e.ovf));
                chk("sb_zero", 64'(zero), 64'(e.zero));
                n_pop++;
                ret_count++;
                if (ret_count == 1) first_ret = tick_no;
                last_ret = tick_no;
            end
        end
        @(negedge clk);
        tick_no++;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic rand_ops();
        a        = $urandom;
        b        = $urandom;
        sub      = 1'($urandom_range(1, 0));
        carry_in = 1'($urandom_range(1, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          seen;
        logic [31:0] snap_sum;
        logic        snap_co, snap_ovf, snap_zero;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[7] = '{32'h00FF_00FF, 32'h0000_FF01, 1'b0, 1'b0, '{32'h0100_0000, 1'b0, 1'b0, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; sub = 1'b0; carry_in = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_carry_out", 64'(carry_out), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, with latency measured.
        foreach (vecs[i]) begin
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
            sub = vecs[i].sub; carry_in = vecs[i].cin;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                tick();
                lat++;
            end
            chk("vec_latency", 64'(lat), 64'(LAT));
            chk("vec_sum", 64'(sum), 64'(vecs[i].r.sum));
            chk("vec_carry_out", 64'(carry_out), 64'(vecs[i].r.co));
            chk("vec_overflow", 64'(overflow), 64'(vecs[i].r.ovf));
            chk("vec_zero", 64'(zero), 64'(vecs[i].r.zero));
            tick();
        end
        drain("vec_drain");

        // Back-to-back random stream.
        ret_count = 0; first_ret = 0; last_ret = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        drain("stream_drain");
        chk("stream_count", 64'(ret_count), 64'd8);
        chk("stream_consecutive", 64'(last_ret - first_ret), 64'd7);

        // Backpressure: fill, stall 3 cycles while offering more, then release.
        seen = 0;
        while (!out_valid && seen < 12) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
            seen++;
        end
        chk("bp_filled", 64'(out_valid), 64'd1);
        snap_sum = sum; snap_co = carry_out; snap_ovf = overflow; snap_zero = zero;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_ops();
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_sum_stable", 64'(sum), 64'(snap_sum));
            chk("bp_flags_stable", 64'({carry_out, overflow, zero}), 64'({snap_co, snap_ovf, snap_zero}));
            tick();
        end
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_balance", 64'(n_pop), 64'(n_push));

        // Reset with three operations in flight, plus one offered during reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        rand_ops();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        n_push -= exp_q.size();
        exp_q.delete();
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_outputs", 64'({carry_out, overflow, zero, sum}), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("rst_no_stale_results", 64'(seen), 64'd0);
        chk("final_balance", 64'(n_pop), 64'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
